// File: rtl/voice_mix_sched.sv
// voice_mix_sched: per-frame mixer scheduler for a shared I2S sample slot.
// On an accepted frame_tick it polls each enabled voice in index order over
// a req/ack handshake, sums the returned signed samples in a widened
// accumulator, saturates to SAMPLE_W and presents the result with a
// one-cycle strobe.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   frame_tick    one-cycle pulse that starts a mix frame when idle
//   voice_en      voice enable mask, captured on an accepted frame_tick
//   voice_req     one-hot request to the voice currently being polled
//   voice_ack     per-voice acknowledge; data valid in the same cycle
//   voice_data    flattened samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   mix_out       saturated mix, held until the next frame completes
//   mix_valid     one-cycle strobe when mix_out updates
//   clip          set with mix_valid when the sum was clamped
//   busy          high whenever a frame is in progress
//   overrun       one-cycle pulse when frame_tick arrives while busy
//   timeout_err   one-cycle pulse when a voice fails to ack in time
module voice_mix_sched #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic [NUM_VOICES-1:0]            voice_en,
  output logic [NUM_VOICES-1:0]            voice_req,
  input  logic [NUM_VOICES-1:0]            voice_ack,
  input  logic [NUM_VOICES*SAMPLE_W-1:0]   voice_data,
  output logic [SAMPLE_W-1:0]              mix_out,
  output logic                             mix_valid,
  output logic                             clip,
  output logic                             busy,
  output logic                             overrun,
  output logic                             timeout_err
);

  localparam int unsigned ACC_W = SAMPLE_W + 4;
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {5'b00000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {5'b11111, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                   state;
  logic [NUM_VOICES-1:0]    en_q;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         nidx;
  logic [CNT_W-1:0]         to_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [SAMPLE_W-1:0]      samples [NUM_VOICES];
  logic                     sel_en;
  logic                     sel_ack;
  logic                     expire;
  logic                     advance;

  always_comb begin
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      samples[i] = voice_data[i*SAMPLE_W +: SAMPLE_W];
    end
    sel_en  = en_q[idx];
    sel_ack = voice_ack[idx];
    nidx    = idx + 1'b1;
    // Ack on the final allowed cycle takes priority over the timeout.
    expire  = sel_en && !sel_ack && (to_cnt == TO_LAST);
    // A disabled voice occupies exactly one REQ cycle.
    advance = !sel_en || sel_ack || expire;
    acc_sum = acc + {{4{samples[idx][SAMPLE_W-1]}}, samples[idx]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      en_q        <= '0;
      idx         <= '0;
      to_cnt      <= '0;
      acc         <= '0;
      voice_req   <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      clip        <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mix_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            en_q      <= voice_en;
            acc       <= '0;
            idx       <= '0;
            to_cnt    <= '0;
            busy      <= 1'b1;
            voice_req <= voice_en[0] ? NUM_VOICES'(1) : '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (frame_tick) overrun <= 1'b1;
          if (sel_en && sel_ack) acc <= acc_sum;
          if (expire) timeout_err <= 1'b1;
          if (advance) begin
            to_cnt <= '0;
            if (idx == LAST_IDX) begin
              voice_req <= '0;
              state     <= DONE;
            end else begin
              idx       <= nidx;
              voice_req <= en_q[nidx] ? (NUM_VOICES'(1) << nidx) : '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          if (frame_tick) overrun <= 1'b1;
          if (acc > SAT_MAX) begin
            mix_out <= {1'b0, {(SAMPLE_W-1){1'b1}}};
            clip    <= 1'b1;
          end else if (acc < SAT_MIN) begin
            mix_out <= {1'b1, {(SAMPLE_W-1){1'b0}}};
            clip    <= 1'b1;
          end else begin
            mix_out <= acc[SAMPLE_W-1:0];
            clip    <= 1'b0;
          end
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mix_sched.sv
// tb_voice_mix_sched: self-checking bench for voice_mix_sched.
// A frame-level model turns each accepted tick into a per-cycle table of
// expected outputs; a single compare process checks every cycle.
module tb_voice_mix_sched;

  localparam int NV   = 4;
  localparam int SW   = 16;
  localparam int TO   = 16;
  localparam int MAXC = 16384;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frame_tick;
  logic [NV-1:0]        voice_en;
  logic [NV-1:0]        voice_req;
  logic [NV-1:0]        voice_ack;
  logic [NV*SW-1:0]     voice_data;
  logic [SW-1:0]        mix_out;
  logic                 mix_valid;
  logic                 clip;
  logic                 busy;
  logic                 overrun;
  logic                 timeout_err;
  logic signed [SW-1:0] mix_s;

  voice_mix_sched #(.NUM_VOICES(NV), .SAMPLE_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .voice_en(voice_en),
    .voice_req(voice_req), .voice_ack(voice_ack), .voice_data(voice_data),
    .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  assign mix_s = mix_out;

  // voice responders
  int                   dly [NV];
  logic signed [SW-1:0] dat [NV];
  int                   wcnt [NV];
  logic [NV-1:0]        noise;
  bit                   noise_on;

  assign voice_data = {dat[3], dat[2], dat[1], dat[0]};

  always_comb begin
    voice_ack = '0;
    for (int i = 0; i < NV; i++)
      voice_ack[i] = (voice_req[i] && (wcnt[i] >= dly[i])) || (!voice_req[i] && noise[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NV; i++) wcnt[i] <= voice_req[i] ? wcnt[i] + 1 : 0;
  end

  always @(negedge clk) noise = noise_on ? 4'($urandom) : 4'b0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected-output tables indexed by cycle
  logic [NV-1:0]        e_req   [MAXC];
  bit                   e_busy  [MAXC];
  bit                   e_valid [MAXC];
  bit                   e_terr  [MAXC];
  bit                   e_ovr   [MAXC];
  bit                   e_upd   [MAXC];
  logic signed [SW-1:0] e_mix   [MAXC];
  bit                   e_clip  [MAXC];

  int                   busy_until = -1;
  int                   last_t0;
  int                   model_mix;
  logic signed [SW-1:0] hold_mix = '0;
  bit                   hold_clip = 1'b0;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int terr_cnt = 0;
  int ovr_cnt = 0;
  int last_valid_cyc = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int from);
    for (int c = from; c < MAXC; c++) begin
      e_req[c] = '0; e_busy[c] = 0; e_valid[c] = 0; e_terr[c] = 0;
      e_ovr[c] = 0; e_upd[c] = 0; e_mix[c] = '0; e_clip[c] = 0;
    end
  endtask

  // Frame model: each enabled voice holds req for min(delay+1, TIMEOUT)
  // cycles, disabled voices take one silent cycle, then one DONE cycle.
  task automatic start_frame(input int t0);
    int t;
    int sum;
    int dur;
    t = t0;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (voice_en[i]) begin
        dur = (dly[i] + 1 > TO) ? TO : dly[i] + 1;
        for (int k = 0; k < dur; k++) e_req[t+k] = 4'(1 << i);
        if (dly[i] + 1 > TO) e_terr[t+dur] = 1;
        else sum += int'(dat[i]);
        t += dur;
      end else begin
        t += 1;
      end
    end
    for (int c = t0; c <= t; c++) e_busy[c] = 1;
    e_valid[t+1] = 1;
    e_upd[t+1] = 1;
    if (sum > 32767) begin
      e_mix[t+1] = 16'sd32767; e_clip[t+1] = 1; model_mix = 32767;
    end else if (sum < -32768) begin
      e_mix[t+1] = -16'sd32768; e_clip[t+1] = 1; model_mix = -32768;
    end else begin
      e_mix[t+1] = 16'(sum); e_clip[t+1] = 0; model_mix = sum;
    end
    busy_until = t;
    last_t0 = t0;
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (e_upd[cyc]) begin
        hold_mix = e_mix[cyc];
        hold_clip = e_clip[cyc];
      end
      chk("voice_req", voice_req, e_req[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("mix_valid", mix_valid, e_valid[cyc]);
      chk("timeout_err", timeout_err, e_terr[cyc]);
      chk("overrun", overrun, e_ovr[cyc]);
      chk("mix_out", mix_s, hold_mix);
      chk("clip", clip, hold_clip);
    end
    if (mix_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (timeout_err) terr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic do_tick();
    int c;
    c = cyc;
    if (c > busy_until) start_frame(c + 1);
    else if (c + 1 < MAXC) e_ovr[c+1] = 1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (cyc < busy_until + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_done cyc=%0d actual=timeout required=frame_end", cyc);
    end
  endtask

  task automatic set_voices(input int d0, input int d1, input int d2, input int d3);
    dat[0] = 16'(d0); dat[1] = 16'(d1); dat[2] = 16'(d2); dat[3] = 16'(d3);
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  task automatic directed(input logic [NV-1:0] en, input int exp_mix,
                          input bit exp_clip, input int exp_lat);
    voice_en = en;
    last_valid_cyc = -1;
    do_tick();
    wait_done();
    chk("pin_model_mix", model_mix, exp_mix);
    chk("pin_mix", mix_s, exp_mix);
    chk("pin_clip", clip, exp_clip);
    chk("pin_latency", last_valid_cyc - last_t0, exp_lat);
  endtask

  initial begin
    int v0;
    int o0;
    int t0c;
    int r;
    clear_from(0);
    rst = 1'b1;
    frame_tick = 1'b0;
    voice_en = '0;
    noise_on = 0;
    set_voices(0, 0, 0, 0);
    set_delays(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_req", voice_req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mix", mix_out, 0);
    chk("reset_valid", mix_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic mix, acks tied to requests
    set_voices(1000, 2000, -500, 250);
    directed(4'b1111, 2750, 0, 5);
    // saturation both directions
    set_voices(20000, 20000, 20000, 20000);
    directed(4'b1111, 32767, 1, 5);
    set_voices(-20000, -20000, -20000, -20000);
    directed(4'b1111, -32768, 1, 5);
    // masked voices, stray acks on other bits
    noise_on = 1;
    set_voices(100, 9999, -40, 9999);
    directed(4'b0101, 60, 0, 5);
    noise_on = 0;
    // all voices disabled
    directed(4'b0000, 0, 0, 5);
    // voice 1 silent (timeout), voice 2 late by 3 cycles
    set_voices(1000, 2000, -500, 250);
    set_delays(0, 1000, 3, 0);
    t0c = terr_cnt;
    directed(4'b1111, 750, 0, 23);
    chk("timeout_pulses", terr_cnt - t0c, 1);
    // ack on the last allowed cycle beats the timeout
    set_delays(TO - 1, 0, 0, 0);
    directed(4'b0001, 1000, 0, 5 + TO - 1);

    // second tick two cycles after the first
    set_delays(0, 0, 0, 0);
    voice_en = 4'b1111;
    v0 = valid_cnt;
    o0 = ovr_cnt;
    do_tick();
    @(negedge clk);
    do_tick();
    wait_done();
    chk("overrun_pulses", ovr_cnt - o0, 1);
    chk("overrun_valids", valid_cnt - v0, 1);
    chk("overrun_mix", mix_s, 2750);

    // asynchronous reset mid-frame
    do_tick();
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_req", voice_req, 4'b0100);
    v0 = valid_cnt;
    #2 rst = 1'b1;
    clear_from(cyc + 1);
    busy_until = -1;
    hold_mix = '0;
    hold_clip = 1'b0;
    #1;
    chk("async_req", voice_req, 0);
    chk("async_busy", busy, 0);
    chk("async_mix", mix_out, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("reset_no_valid", valid_cnt - v0, 0);
    set_voices(-300, 700, 5, -2);
    directed(4'b1111, 403, 0, 5);

    // randomized frames
    for (int n = 0; n < 60; n++) begin
      voice_en = 4'($urandom);
      noise_on = bit'($urandom_range(0, 1));
      for (int i = 0; i < NV; i++) begin
        if ($urandom_range(0, 1) == 0) dat[i] = 16'($urandom);
        else dat[i] = 16'(int'($urandom_range(0, 400)) - 200);
        r = int'($urandom_range(0, 9));
        if (r < 6) dly[i] = r % 3;
        else if (r == 6) dly[i] = TO - 2;
        else if (r == 7) dly[i] = TO - 1;
        else if (r == 8) dly[i] = TO;
        else dly[i] = 1000;
      end
      do_tick();
      if ($urandom_range(0, 1) == 0) voice_en = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        do_tick();
      end
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    noise_on = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
